// File: rtl/sram_tp_reg_array.sv
// sram_tp_reg_array: flip-flop two-port memory (1W + 1R) with synchronous read and optional output register
module sram_tp_reg_array #(
  parameter int KNOB_REGOUT = 0,
  parameter int SIZE = 4,
  parameter int DATA_WD = 8,
  localparam int SIZE_WD = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_val_i,
  input  logic [SIZE_WD-1:0] wr_adr_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic               rd_val_i,
  output logic               rd_val_o,
  input  logic [SIZE_WD-1:0] rd_adr_i,
  output logic [DATA_WD-1:0] rd_dat_o
);
  localparam logic [SIZE_WD:0] SIZE_L = (SIZE_WD + 1)'(SIZE);
  logic [DATA_WD-1:0] mem [SIZE];
  logic [DATA_WD-1:0] rd_mem;
  logic [DATA_WD-1:0] r1_dat;
  logic               r1_val;
  // Word array; writes outside the populated range are dropped
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    else if (wr_val_i && ({1'b0, wr_adr_i} < SIZE_L))
      mem[wr_adr_i] <= wr_dat_i;
  // Array lookup; an unpopulated address reads as zero
  always_comb rd_mem = ({1'b0, rd_adr_i} < SIZE_L) ? mem[rd_adr_i] : '0;
  // First read stage; data holds while no read is issued so a waiting consumer sees it stable
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r1_dat <= '0;
      r1_val <= 1'b0;
    end else begin
      r1_val <= rd_val_i;
      if (rd_val_i) r1_dat <= rd_mem;
    end
  if (KNOB_REGOUT != 0) begin : g_reg
    logic [DATA_WD-1:0] r2_dat;
    logic               r2_val;
    // Output stage follows the first stage one cycle later, loading only on valid data
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        r2_dat <= '0;
        r2_val <= 1'b0;
      end else begin
        r2_val <= r1_val;
        if (r1_val) r2_dat <= r1_dat;
      end
    assign rd_dat_o = r2_dat;
    assign rd_val_o = r2_val;
  end else begin : g_noreg
    assign rd_dat_o = r1_dat;
    assign rd_val_o = r1_val;
  end
endmodule

// File: tb/tb_sram_tp_reg_array.sv
// tb_sram_tp_reg_array: directed checks of the two-port register array in three configurations
module tb_sram_tp_reg_array;
  logic       clk;
  logic       rstn;
  logic       wr_val, rd_val;
  logic [1:0] wr_adr, rd_adr;
  logic [7:0] wr_dat;
  logic       val0, val1;
  logic [7:0] dat0, dat1;
  logic       wr_val5, rd_val5;
  logic [2:0] wr_adr5, rd_adr5;
  logic [7:0] wr_dat5;
  logic       val5;
  logic [7:0] dat5;
  int         errors = 0;
  int         checks = 0;

  sram_tp_reg_array #(.KNOB_REGOUT(0), .SIZE(4), .DATA_WD(8)) u0 (
    .clk(clk), .rstn(rstn), .wr_val_i(wr_val), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_val_o(val0), .rd_adr_i(rd_adr), .rd_dat_o(dat0));
  sram_tp_reg_array #(.KNOB_REGOUT(1), .SIZE(4), .DATA_WD(8)) u1 (
    .clk(clk), .rstn(rstn), .wr_val_i(wr_val), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_val_o(val1), .rd_adr_i(rd_adr), .rd_dat_o(dat1));
  sram_tp_reg_array #(.KNOB_REGOUT(0), .SIZE(5), .DATA_WD(8)) u2 (
    .clk(clk), .rstn(rstn), .wr_val_i(wr_val5), .wr_adr_i(wr_adr5), .wr_dat_i(wr_dat5),
    .rd_val_i(rd_val5), .rd_val_o(val5), .rd_adr_i(rd_adr5), .rd_dat_o(dat5));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 0;
    {wr_val, wr_adr, wr_dat, rd_val, rd_adr} = '0;
    {wr_val5, wr_adr5, wr_dat5, rd_val5, rd_adr5} = '0;
    #12;
    chk("rst_val0", val0, 0);
    chk("rst_dat0", dat0, 0);
    chk("rst_val1", val1, 0);
    rstn = 1;
    tick;
    // reset mid-run with a read in flight
    wr_val = 1; wr_adr = 0; wr_dat = 8'h55;
    tick;
    wr_val = 0; rd_val = 1; rd_adr = 0;
    tick;
    chk("pre_rst_val", val0, 1);
    chk("pre_rst_dat", dat0, 8'h55);
    rstn = 0;
    #1;
    chk("mid_rst_val0", val0, 0);
    chk("mid_rst_dat0", dat0, 0);
    chk("mid_rst_val1", val1, 0);
    chk("mid_rst_dat1", dat1, 0);
    #2 rstn = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      rd_adr = 2'(i);
      tick;
      chk($sformatf("clr_dat%0d", i), dat0, 0);
      chk($sformatf("clr_val%0d", i), val0, 1);
    end
    rd_val = 0;
    // write then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      wr_val = 1; wr_adr = 2'(i); wr_dat = 8'(8'h11 * (i + 1));
      tick;
    end
    wr_val = 0;
    tick;
    rd_val = 1;
    for (int i = 0; i < 4; i++) begin
      rd_adr = 2'(i);
      tick;
      chk($sformatf("rd_dat%0d", i), dat0, 8'h11 * (i + 1));
      chk($sformatf("rd_val%0d", i), val0, 1);
      if (i > 0) chk($sformatf("r2_dat%0d", i), dat1, 8'h11 * i);
    end
    // hold
    rd_adr = 2;
    tick;
    chk("hold_first", dat0, 8'h33);
    rd_val = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("hold_dat%0d", i), dat0, 8'h33);
      chk($sformatf("hold_val%0d", i), val0, 0);
      chk($sformatf("hold_r2dat%0d", i), dat1, 8'h33);
      chk($sformatf("hold_r2val%0d", i), val1, i == 0);
    end
    // read-during-write to the same address returns the old word
    wr_val = 1; wr_adr = 1; wr_dat = 8'hAA; rd_val = 1; rd_adr = 1;
    tick;
    chk("coll_old", dat0, 8'h22);
    wr_val = 0;
    tick;
    chk("coll_new", dat0, 8'hAA);
    rd_val = 0;
    tick;
    tick;
    // two-cycle latency with the output register
    rd_val = 1; rd_adr = 3;
    tick;
    chk("ro_n_val", val1, 0);
    chk("ro_n_dat", dat1, 8'hAA);
    rd_val = 0;
    tick;
    chk("ro_n1_val", val1, 1);
    chk("ro_n1_dat", dat1, 8'h44);
    tick;
    chk("ro_n2_val", val1, 0);
    chk("ro_n2_dat", dat1, 8'h44);
    // non-power-of-2 depth
    wr_val5 = 1; wr_adr5 = 4; wr_dat5 = 8'h5A;
    tick;
    wr_adr5 = 6; wr_dat5 = 8'h77;
    tick;
    wr_val5 = 0; rd_val5 = 1; rd_adr5 = 4;
    tick;
    chk("np2_rd4", dat5, 8'h5A);
    rd_adr5 = 6;
    tick;
    chk("np2_rd6", dat5, 0);
    chk("np2_val6", val5, 1);
    rd_adr5 = 2;
    tick;
    chk("np2_rd2", dat5, 0);
    rd_adr5 = 5;
    tick;
    chk("np2_rd5", dat5, 0);
    rd_val5 = 0;
    tick;
    chk("np2_idle", val5, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
